// File: rtl/conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : conv_pkg                                                          |
// | Brief  : Shared helpers for the CNN datapath (adder tree, pooling, act.)   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package conv_pkg;

    // $clog2 that never returns less than 1, so single-level trees stay legal.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Clamp a signed value into the range representable by a width-bit signed word.
    function automatic longint sat_trunc(input longint value, input int width);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (width - 1)) - longint'(1);
        lo = -(longint'(1) <<< (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage : conv_pkg
`default_nettype wire

// File: rtl/adder_tree_level.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : adder_tree_level                                                  |
// | Brief  : One registered level of a signed binary adder tree                |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module adder_tree_level
    import conv_pkg::*;
#(
    parameter int N_NODES = 3,
    parameter int IN_W    = 19,
    parameter int N_OUT   = (N_NODES + 1) / 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_NODES*IN_W-1:0]   in_nodes,
    output logic [N_OUT*(IN_W+1)-1:0] out_nodes
);

    genvar j;
    generate
        for (j = 0; j < N_NODES / 2; j++) begin : g_pair
            logic [IN_W-1:0] a;
            logic [IN_W-1:0] b;
            logic [IN_W:0]   node_q;

            assign a = in_nodes[(2*j)*IN_W   +: IN_W];
            assign b = in_nodes[(2*j+1)*IN_W +: IN_W];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    node_q <= '0;
                end else begin
                    node_q <= {a[IN_W-1], a} + {b[IN_W-1], b};
                end
            end

            assign out_nodes[j*(IN_W+1) +: IN_W+1] = node_q;
        end

        if ((N_NODES % 2) != 0) begin : g_odd
            logic [IN_W-1:0] a;
            logic [IN_W:0]   node_q;

            assign a = in_nodes[(N_NODES-1)*IN_W +: IN_W];

            // Leftover node keeps pace with its siblings: registered and widened.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    node_q <= '0;
                end else begin
                    node_q <= {a[IN_W-1], a};
                end
            end

            assign out_nodes[(N_OUT-1)*(IN_W+1) +: IN_W+1] = node_q;
        end
    endgenerate

endmodule : adder_tree_level
`default_nettype wire

// File: rtl/conv_adder_tree.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : conv_adder_tree                                                   |
// | Brief  : Pipelined signed adder tree with multi-beat accumulation.         |
// |          Define CONV_ADDER_TREE_SAT_EN to saturate the result to OUT_W.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module conv_adder_tree
    import conv_pkg::*;
#(
    parameter int NUM_IN  = 3,
    parameter int IN_W    = 19,
    parameter int ACC_EXT = 4,
    parameter int OUT_W   = 21
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN*IN_W-1:0]   in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    output logic                     out_sat
);

    localparam int LVL   = clog2_min1(NUM_IN);
    localparam int SUM_W = IN_W + LVL;
    localparam int ACC_W = SUM_W + ACC_EXT;

    genvar k;
    generate
        for (k = 0; k < LVL; k++) begin : g_lvl
            localparam int NI = (NUM_IN + (1 << k) - 1) >> k;
            localparam int NO = (NI + 1) / 2;
            localparam int WI = IN_W + k;

            logic [NO*(WI+1)-1:0] lvl_out;

            if (k == 0) begin : g_first
                adder_tree_level #(
                    .N_NODES (NI),
                    .IN_W    (WI)
                ) u_level (
                    .clk       (clk),
                    .rst_n     (rst_n),
                    .in_nodes  (in_data),
                    .out_nodes (lvl_out)
                );
            end else begin : g_next
                adder_tree_level #(
                    .N_NODES (NI),
                    .IN_W    (WI)
                ) u_level (
                    .clk       (clk),
                    .rst_n     (rst_n),
                    .in_nodes  (g_lvl[k-1].lvl_out),
                    .out_nodes (lvl_out)
                );
            end
        end
    endgenerate

    logic [SUM_W-1:0] tree_sum;
    logic [ACC_W-1:0] sum_ext;
    assign tree_sum = g_lvl[LVL-1].lvl_out;
    assign sum_ext  = {{ACC_EXT{tree_sum[SUM_W-1]}}, tree_sum};

    // valid/last shadow the tree so they emerge together with its sum
    logic [LVL-1:0] vld_pipe;
    logic [LVL-1:0] last_pipe;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            for (int i = LVL - 1; i > 0; i--) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
            vld_pipe[0]  <= in_valid;
            last_pipe[0] <= in_valid & in_last;
        end
    end

    logic tree_vld;
    logic tree_last;
    assign tree_vld  = vld_pipe[LVL-1];
    assign tree_last = last_pipe[LVL-1];

    logic signed [ACC_W-1:0] acc;
    logic                    first;
    logic                    acc_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            first    <= 1'b1;
            acc_done <= 1'b0;
        end else begin
            acc_done <= tree_vld & tree_last;
            if (tree_vld) begin
                acc   <= (first ? '0 : acc) + sum_ext;
                first <= tree_last;
            end else if (acc_done) begin
                acc <= '0;
            end
        end
    end

    logic [OUT_W-1:0] result;

`ifdef CONV_ADDER_TREE_SAT_EN
    longint acc_l;
    longint sat_l;
    logic   sat_hit;

    assign acc_l   = longint'(acc);
    assign sat_l   = sat_trunc(acc_l, OUT_W);
    assign sat_hit = (sat_l != acc_l);
    assign result  = OUT_W'(sat_l);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_sat <= 1'b0;
        end else begin
            out_sat <= acc_done & sat_hit;
        end
    end
`else
    assign result  = acc[OUT_W-1:0];
    assign out_sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= acc_done;
            if (acc_done) begin
                out_data <= result;
            end
        end
    end

endmodule : conv_adder_tree
`default_nettype wire

// File: tb/tb_conv_adder_tree.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_conv_adder_tree                                                |
// | Brief  : Directed self-checking bench for conv_adder_tree                  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_conv_adder_tree;

    localparam int NUM_IN = 3;
    localparam int IN_W   = 19;
    localparam int OUT_W  = 21;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_IN*IN_W-1:0]   in_data;
    logic                     in_valid;
    logic                     in_last;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_valid;
    logic                     out_sat;

    int n_assert;
    int n_fail;

    conv_adder_tree #(
        .NUM_IN  (NUM_IN),
        .IN_W    (IN_W),
        .ACC_EXT (4),
        .OUT_W   (OUT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input int a, input int b, input int c, input bit last);
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] vc;
        va = a;
        vb = b;
        vc = c;
        @(negedge clk);
        in_data  = {vc[IN_W-1:0], vb[IN_W-1:0], va[IN_W-1:0]};
        in_valid = 1'b1;
        in_last  = last;
    endtask

    // Called right after the last beat; a correct pulse shows at the 4th negedge.
    task automatic expect_result(input string tag, input int exp_data, input bit exp_sat);
        int lat;
        lat = 0;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (out_valid === 1'b1) lat = n;
        end
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_data"}, out_data, exp_data);
        chk({tag, "_sat"}, {31'd0, out_sat}, {31'd0, exp_sat});
        @(negedge clk);
        chk({tag, "_pulse_end"}, {31'd0, out_valid}, 0);
        chk({tag, "_hold"}, out_data, exp_data);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_data",  out_data, 0);
        chk("reset_valid", {31'd0, out_valid}, 0);
        chk("reset_sat",   {31'd0, out_sat}, 0);
        rst_n = 1'b1;

        beat(100, -30, 5, 1'b1);
        expect_result("mixed", 75, 1'b0);

        beat(-262144, -262144, -262144, 1'b1);
        expect_result("min_ops", -786432, 1'b0);

        beat(262143, 262143, 262143, 1'b0);
        beat(262143, 262143, 262143, 1'b0);
        beat(262143, 262143, 262143, 1'b0);
        beat(262143, 262143, 262143, 1'b1);
`ifdef CONV_ADDER_TREE_SAT_EN
        expect_result("overflow", 1048575, 1'b1);
`else
        expect_result("overflow", 1048564, 1'b0);
`endif
        chk("sat_clear", {31'd0, out_sat}, 0);

        beat(1, 2, 3, 1'b0);
        beat(4, 5, 6, 1'b1);
        expect_result("contig", 21, 1'b0);

        beat(1, 2, 3, 1'b0);
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b1;
            chk("gap_no_pulse", {31'd0, out_valid}, 0);
        end
        beat(4, 5, 6, 1'b1);
        expect_result("gapped", 21, 1'b0);

        beat(1, 1, 1, 1'b1);
        beat(2, 2, 2, 1'b1);
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        chk("b2b_first_valid", {31'd0, out_valid}, 1);
        chk("b2b_first_data",  out_data, 3);
        @(negedge clk);
        chk("b2b_second_valid", {31'd0, out_valid}, 1);
        chk("b2b_second_data",  out_data, 6);
        @(negedge clk);
        chk("b2b_end", {31'd0, out_valid}, 0);

        beat(10, 10, 10, 1'b0);
        beat(10, 10, 10, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", {31'd0, out_valid}, 0);
        chk("rst_mid_data",  out_data, 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_pulse", {31'd0, out_valid}, 0);
        end
        beat(1, 0, 0, 1'b1);
        expect_result("after_rst", 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_conv_adder_tree
`default_nettype wire
